reg_scoreboard: RTL and testbench

- Parametrised register-busy scoreboard for the in-order issue stage; successor to the single-bit busy vector.
- Each architectural register has an outstanding-write counter, so several in-flight writes to one register (WAW) are tracked correctly.
- Generalised to N source ports, configurable counter depth, flush and an error flag.
- Sits between decode/issue and writeback; drives the issue stall.

---
 rtl/scb_pkg.sv | 16 +
 rtl/scb_counter.sv | 41 ++++
 rtl/reg_scoreboard.sv | 94 +++++++++
 tb/tb_reg_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/scb_pkg.sv
// Shared defaults and types for the register-busy scoreboard.
package scb_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int CW_DEF   = 2;

    typedef logic [CW_DEF-1:0] cnt_t;
    typedef logic [AW_DEF-1:0] reg_idx_t;

    // Largest count a CW-bit counter may hold before issue must stall.
    function automatic int cnt_max(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/scb_counter.sv
// Per-register outstanding-write counter: saturating up/down, clr beats inc/dec, 1-cycle update.
// Underflow flags a decrement against an empty count that no increment cancels.
module scb_counter
    import scb_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          underflow
);

    localparam logic [CW-1:0] MAX = CW'(cnt_max(CW));

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q != MAX) count_d = count_q + CW'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count     = count_q;
    assign underflow = dec & ~inc & ~clr & (count_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for in-order issue: per-register write counters, combinational stall outputs.
// Build option SCB_WB_BYPASS_EN: a source retiring its last write this cycle is treated as ready.
module reg_scoreboard
    import scb_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = AW_DEF,
    parameter int CW       = CW_DEF,
    parameter int NRS      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic              iss_wen,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRS-1:0]    iss_ren,
    input  logic [NRS*AW-1:0] iss_rs,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [AW-1:0]     wb_rd,
    input  logic              flush,
    output logic              hazard,
    output logic              sat_stall,
    output logic              iss_ready,
    output logic [NREG-1:0]   busy_vec,
    output logic              err
);

    localparam logic [CW-1:0] CNT_MAX = CW'(cnt_max(CW));

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] udf;
    logic            iss_fire;
    logic            wb_fire;
    logic            err_q;
    logic            err_d;
    logic [AW-1:0]   rs_k;
    logic            src_busy;

    assign iss_fire = iss_valid & iss_ready & iss_wen & ~flush;
    assign wb_fire  = wb_valid & wb_wen & ~flush;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam bit HARDWIRED = (ZERO_REG != 0) && (r == 0);

        assign inc[r] = iss_fire && (iss_rd == AW'(r)) && !HARDWIRED;
        assign dec[r] = wb_fire  && (wb_rd  == AW'(r)) && !HARDWIRED;

        scb_counter #(.CW(CW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .clr       (flush),
            .count     (cnt[r]),
            .underflow (udf[r])
        );

        assign busy_vec[r] = (cnt[r] != '0);
    end

    always_comb begin
        hazard   = 1'b0;
        rs_k     = '0;
        src_busy = 1'b0;
        for (int k = 0; k < NRS; k++) begin
            rs_k     = iss_rs[k*AW +: AW];
            src_busy = busy_vec[rs_k];
            if ((ZERO_REG != 0) && (rs_k == '0)) src_busy = 1'b0;
`ifdef SCB_WB_BYPASS_EN
            // Last outstanding write retires now; its value is forwarded to issue.
            if (wb_fire && (wb_rd == rs_k) && (cnt[rs_k] == CW'(1))) src_busy = 1'b0;
`endif
            hazard = hazard | (iss_valid & iss_ren[k] & src_busy);
        end
    end

    assign sat_stall = iss_valid & iss_wen & (cnt[iss_rd] == CNT_MAX)
                     & ~((ZERO_REG != 0) && (iss_rd == '0));
    assign iss_ready = ~hazard & ~sat_stall;

    assign err_d = err_q | (|udf);

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard with an expected-output queue, plus a WAW saturation sequence.
module tb_reg_scoreboard;
    import scb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_wen, wb_valid, wb_wen, flush;
    logic [4:0]  iss_rd, wb_rd;
    logic [1:0]  iss_ren;
    logic [9:0]  iss_rs;
    logic        hazard, sat_stall, iss_ready, err;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

`ifdef SCB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_wen   (iss_wen),
        .iss_rd    (iss_rd),
        .iss_ren   (iss_ren),
        .iss_rs    (iss_rs),
        .wb_valid  (wb_valid),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .hazard    (hazard),
        .sat_stall (sat_stall),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, iw;
        logic [4:0]  rd;
        logic [1:0]  ren;
        logic [4:0]  rs0, rs1;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl, rs;
        logic        eh, es;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    typedef struct {
        logic        h, s, r;
        logic [31:0] b;
        logic        e;
    } exp_t;

    vec_t vt[$];
    exp_t expq[$];

    function automatic logic [31:0] b(input int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t mk(input logic iv, input logic iw, input int rd, input logic [1:0] ren,
                                input int rs0, input int rs1, input logic wv, input int wrd,
                                input logic fl, input logic rs, input logic eh, input logic es,
                                input logic [31:0] eb, input logic ee);
        vec_t v;
        v.iv = iv; v.iw = iw; v.rd = 5'(rd); v.ren = ren; v.rs0 = 5'(rs0); v.rs1 = 5'(rs1);
        v.wv = wv; v.wrd = 5'(wrd); v.fl = fl; v.rs = rs;
        v.eh = eh; v.es = es; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_ren = 0; iss_rs = 0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0; flush = 0; rst = 0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e, g;
        @(negedge clk);
        iss_valid = v.iv; iss_wen = v.iw; iss_rd = v.rd; iss_ren = v.ren;
        iss_rs = {v.rs1, v.rs0};
        wb_valid = v.wv; wb_wen = v.wv; wb_rd = v.wrd; flush = v.fl; rst = v.rs;
        e.h = v.eh; e.s = v.es; e.r = ~v.eh & ~v.es; e.b = v.eb; e.e = v.ee;
        expq.push_back(e);
        #1;
        g = expq.pop_front();
        check($sformatf("row%0d hazard", idx),    32'(hazard),    32'(g.h));
        check($sformatf("row%0d sat_stall", idx), 32'(sat_stall), 32'(g.s));
        check($sformatf("row%0d iss_ready", idx), 32'(iss_ready), 32'(g.r));
        check($sformatf("row%0d busy_vec", idx),  busy_vec,       g.b);
        check($sformatf("row%0d err", idx),       32'(err),       32'(g.e));
    endtask

    initial begin
        int acc;
        bit sat_seen;

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);

        //          iv iw rd ren   rs0 rs1 wv wrd fl rs  eh  es  busy            err
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));         // reset state
        vt.push_back(mk(1, 1, 5, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));         // issue rd5
        vt.push_back(mk(1, 0, 0, 2'b01, 5, 0,  0, 0,  0, 0, 1, 0, b(5), 0));          // read 5 -> hazard
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 5,  0, 0, 0, 0, b(5), 0));          // retire 5
        vt.push_back(mk(1, 0, 0, 2'b01, 5, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));         // 5 free
        vt.push_back(mk(1, 1, 7, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));         // WAW 1
        vt.push_back(mk(1, 1, 7, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, b(7), 0));          // WAW 2
        vt.push_back(mk(1, 1, 7, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, b(7), 0));          // WAW 3
        vt.push_back(mk(1, 1, 7, 2'b00, 0, 0,  0, 0,  0, 0, 0, 1, b(7), 0));          // 4th: saturated
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 7,  0, 0, 0, 0, b(7), 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 7,  0, 0, 0, 0, b(7), 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 7,  0, 0, 0, 0, b(7), 0));          // still busy before 3rd retire lands
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(1, 1, 3, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));         // issue rd3
        vt.push_back(mk(1, 1, 3, 2'b00, 0, 0,  1, 3,  0, 0, 0, 0, b(3), 0));          // issue+wb same reg
        vt.push_back(mk(1, 1, 4, 2'b00, 0, 0,  1, 3,  0, 0, 0, 0, b(3), 0));          // issue 4, wb 3
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, b(4), 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 4,  0, 0, 0, 0, b(4), 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 0,  0, 0, 0, 0, 32'h0, 0));         // wb r0 ignored
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  1, 9,  0, 0, 0, 0, 32'h0, 0));         // underflow
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 1));
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 1));         // sticky
        vt.push_back(mk(1, 1, 0, 2'b01, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 1));         // issue rd0, read r0
        vt.push_back(mk(1, 1, 2, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 1));         // r0 never marked
        vt.push_back(mk(1, 1, 6, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, b(2), 1));
        vt.push_back(mk(1, 1, 8, 2'b00, 0, 0,  1, 2,  1, 0, 0, 0, b(2) | b(6), 1));   // flush wins
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 1));
        vt.push_back(mk(1, 1, 10, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0, 1));
        vt.push_back(mk(1, 0, 0, 2'b10, 0, 10, 0, 0,  0, 0, 1, 0, b(10), 1));         // port 1 hazard
        vt.push_back(mk(1, 0, 0, 2'b01, 11, 10, 0, 0, 0, 0, 0, 0, b(10), 1));         // port 1 disabled
        vt.push_back(mk(0, 0, 0, 2'b11, 10, 10, 0, 0, 0, 0, 0, 0, b(10), 1));         // no valid
        vt.push_back(mk(1, 1, 11, 2'b01, 10, 0, 1, 10, 0, 0, !BYP, 0, b(10), 1));     // bypass case
        vt.push_back(mk(1, 1, 12, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, BYP ? b(11) : 32'h0, 1));
        vt.push_back(mk(1, 1, 13, 2'b00, 0, 0, 0, 0,  1, 1, 0, 0, (BYP ? b(11) : 32'h0) | b(12), 1)); // rst over flush
        vt.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0, 32'h0, 0));

        for (int i = 0; i < vt.size(); i++) apply(i, vt[i]);

        // WAW fill on r15 until saturation, bounded.
        acc = 0;
        sat_seen = 0;
        for (int c = 0; c < 8 && !sat_seen; c++) begin
            @(negedge clk);
            idle_inputs();
            iss_valid = 1; iss_wen = 1; iss_rd = 5'd15;
            #1;
            if (sat_stall) sat_seen = 1;
            else if (iss_ready) acc++;
        end
        check("seq sat reached", 32'(sat_seen), 32'd1);
        check("seq accepted", 32'(acc), 32'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle_inputs();
            wb_valid = 1; wb_wen = 1; wb_rd = 5'd15;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("seq drained busy15", 32'(busy_vec[15]), 32'd0);
        check("seq drained err", 32'(err), 32'd0);
        @(negedge clk);
        wb_valid = 1; wb_wen = 1; wb_rd = 5'd15;
        @(negedge clk);
        idle_inputs();
        #1;
        check("seq extra retire err", 32'(err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
